// File: rtl/centroid_update.sv
// Turns per-class coordinate sums and point counts into new centroids, one class
// at a time, using a bit-serial restoring divider shared across dimensions.
module centroid_update #(
  parameter int n = 8,
  parameter int d = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [n-1:0]           rd_class,
  input  logic [d-1:0][63:0]     rd_sum,
  input  logic [31:0]            rd_count,
  input  logic [d-1:0][31:0]     rd_old,
  output logic                   wr_en,
  output logic [n-1:0]           wr_class,
  output logic [d-1:0][31:0]     wr_centroid,
  output logic                   busy,
  output logic                   done,
  output logic [n:0]             empty_classes
);

  localparam int DIM_W = (d > 1) ? $clog2(d) : 1;

  typedef enum logic [2:0] {IDLE, READ, LATCH, DIV, WRITE, FIN} state_t;

  state_t               state, state_n;
  logic [n-1:0]         idx;
  logic [DIM_W-1:0]     dim;
  logic [5:0]           bit_cnt;
  logic [63:0]          dvd;
  logic [31:0]          rem;
  logic [31:0]          divisor;
  logic [d-1:0][63:0]   sum_q;
  logic [d-1:0][31:0]   res, res_n;

  logic [32:0]          trial;
  logic                 q_bit;
  logic [31:0]          rem_step;
  logic [63:0]          dvd_step;
  logic                 last_bit, last_dim;

  function automatic logic [31:0] sat32(input logic [63:0] q);
    sat32 = (q[63:32] != 32'd0) ? 32'hFFFF_FFFF : q[31:0];
  endfunction

  // One restoring step: the quotient bit shifts into the dividend register,
  // so after 64 steps dvd holds the full quotient.
  always_comb begin
    trial    = {rem, dvd[63]};
    q_bit    = (trial >= {1'b0, divisor});
    rem_step = q_bit ? 32'(trial - {1'b0, divisor}) : trial[31:0];
    dvd_step = {dvd[62:0], q_bit};
    last_bit = (bit_cnt == 6'd63);
    last_dim = (dim == DIM_W'(d - 1));
  end

  always_comb begin
    state_n = state;
    res_n   = res;
    case (state)
      IDLE:  if (start) state_n = READ;
      READ:  state_n = LATCH;
      LATCH: begin
        if (rd_count == 32'd0) begin
          state_n = WRITE;
          res_n   = rd_old;
        end else begin
          state_n = DIV;
        end
      end
      DIV: begin
        if (last_bit) begin
          res_n[dim] = sat32(dvd_step);
          if (last_dim) state_n = WRITE;
        end
      end
      WRITE: state_n = (idx == '1) ? FIN : READ;
      FIN:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      dim           <= '0;
      bit_cnt       <= '0;
      dvd           <= '0;
      rem           <= '0;
      divisor       <= '0;
      sum_q         <= '0;
      res           <= '0;
      rd_class      <= '0;
      wr_en         <= 1'b0;
      wr_class      <= '0;
      wr_centroid   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      empty_classes <= '0;
    end else begin
      state <= state_n;
      res   <= res_n;
      wr_en <= (state_n == WRITE);
      done  <= (state_n == FIN);
      if (state_n == WRITE) begin
        wr_class    <= idx;
        wr_centroid <= res_n;
      end
      case (state)
        IDLE: begin
          if (start) begin
            idx           <= '0;
            rd_class      <= '0;
            empty_classes <= '0;
            busy          <= 1'b1;
          end
        end
        LATCH: begin
          divisor <= rd_count;
          if (rd_count == 32'd0) begin
            empty_classes <= empty_classes + 1'b1;
          end else begin
            dim     <= '0;
            bit_cnt <= '0;
            rem     <= '0;
            dvd     <= rd_sum[0];
            sum_q   <= rd_sum >> 64;
          end
        end
        DIV: begin
          rem     <= rem_step;
          dvd     <= dvd_step;
          bit_cnt <= bit_cnt + 1'b1;
          // Next dimension's dividend is fed from the bottom of the sum queue.
          if (last_bit && !last_dim) begin
            dim   <= dim + 1'b1;
            rem   <= '0;
            dvd   <= sum_q[0];
            sum_q <= sum_q >> 64;
          end
        end
        WRITE: begin
          if (idx == '1) begin
            busy <= 1'b0;
          end else begin
            idx      <= idx + 1'b1;
            rd_class <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/centroid_update.md
# centroid_update

Reads back per-class coordinate sums and point counts produced by the k-means accumulation stage and turns them into new centroids by sequential integer division. It sits after accumulation in each iteration: the controller pulses `start`, the block walks every class index once, and writes one updated centroid per class into the centroid store. It also reports how many classes received no points.

## Interface
- `n`, default 8: log2 of class count; classes are indexed 0 .. 2**n-1.
- `d`, default 2: dimensions per point or centroid.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: one-cycle request to begin an update pass; sampled only in IDLE.
- `rd_class`  out  n: class index being read from the accumulator and centroid stores.
- `rd_sum`  in  [63:0] x d: per-dimension unsigned sum for `rd_class`; valid the cycle after `rd_class` is driven.
- `rd_count`  in  32: unsigned point count for `rd_class`; same timing as `rd_sum`.
- `rd_old`  in  [31:0] x d: current centroid for `rd_class`; same timing as `rd_sum`.
- `wr_en`  out  1: one-cycle write strobe for the new centroid.
- `wr_class`  out  n: class index written when `wr_en` is high.
- `wr_centroid`  out  [31:0] x d: new centroid value written when `wr_en` is high.
- `busy`  out  1: high from the cycle after `start` is accepted until `done`.
- `done`  out  1: one-cycle pulse when the pass completes.
- `empty_classes`  out  n+1: number of classes with `rd_count == 0` in the last pass.

## Operation
- FSM states: IDLE, READ, LATCH, DIV, WRITE, FIN.
- IDLE: if `start` is high, set class index to 0, clear `empty_classes`, set `busy`, and go to READ. `start` is ignored in every other state.
- READ: drive `rd_class` = current index and go to LATCH.
- LATCH: register `rd_sum`, `rd_count`, and `rd_old`.
  - If the count is 0: load `rd_old` into the result registers, increment `empty_classes`, and go to WRITE.
  - Otherwise: dimension index = 0 and go to DIV.
- DIV: restoring shift-subtract division, 64-bit dividend by 32-bit divisor, one quotient bit per cycle, MSB first. This takes 64 cycles per dimension, processed sequentially from dimension 0 to dimension d-1.
  - Each quotient truncates toward zero; the remainder is discarded.
  - If the 64-bit quotient is at least 2**32, the result saturates to 0xFFFFFFFF.
  - After dimension d-1 completes, go to WRITE.
- WRITE: assert `wr_en` with `wr_class` = index and `wr_centroid` = results.
  - If the index is 2**n-1, go to FIN; otherwise increment the index and go to READ.
- FIN: pulse `done`, clear `busy`, and go to IDLE.
- `wr_class` and `wr_centroid` hold their last values outside WRITE. `rd_class` holds its last value outside READ.
- Asynchronous reset, including mid-pass, forces the following values. No partial write is issued, and the pass is abandoned.
  - FSM = IDLE.
  - `busy`, `done`, `wr_en` = 0.
  - `rd_class`, `wr_class` = 0.
  - `wr_centroid` = 0.
  - `empty_classes` = 0.
  - All divider registers = 0.

## Timing
- Read latency: `rd_sum`, `rd_count`, and `rd_old` are sampled exactly one cycle after the READ cycle.
- Cycles per class: nonzero count = 3 + 64·d (READ, LATCH, DIV, WRITE); zero count = 3.
- `busy` rises in the cycle after `start` is sampled.
- `done` is high in the cycle after the final WRITE; `busy` is low in that same cycle.
- `wr_en` is never high on two consecutive cycles.
- Full pass with all counts nonzero: 2**n·(3+64·d)+1 cycles from `busy` rising to `done`.
- `empty_classes` is stable and valid from `done` until the next accepted `start`.

## Test plan
- Basic mean, n=2, d=2, every class has sum=(300,600) and count=3: four writes with `wr_centroid`=(100,200) and `wr_class` 0,1,2,3 in order. `done` follows 4·131+1 cycles after `busy` rises; `empty_classes`=0.
- Truncation and saturation:
  - sum=(10,7), count=3 gives (3,2).
  - sum=(2**40,0), count=1 gives (0xFFFFFFFF,0).
- Empty class: class 2 has count=0 and `rd_old`=(55,66). The write for class 2 is (55,66) and occurs 3 cycles after its READ; `empty_classes`=1 at `done`.
- Start while busy: pulse `start` again mid-DIV. Exactly one pass runs, with 4 writes and one `done` pulse.
- Reset mid-pass: assert `rst` during DIV of class 1.
  - All outputs go to 0 immediately, and no further `wr_en` is issued.
  - A later `start` begins again from class 0.
- Back-to-back passes: pulse `start` the cycle after `done`. The second pass is accepted, and its `empty_classes` reflects only that pass.
